// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller read/write port among NUM_PORTS requesters.
// One transaction in flight; per-port ack/done pulses and a WAIT-state completion watchdog.
module sdram_port_arbiter #(
  parameter int unsigned NUM_PORTS      = 4,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned ADR_WIDTH      = 24,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [NUM_PORTS-1:0]            req_i,
  input  logic [NUM_PORTS-1:0]            we_i,
  input  logic [NUM_PORTS*ADR_WIDTH-1:0]  adr_i,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_PORTS-1:0]            ack_o,
  output logic [NUM_PORTS-1:0]            done_o,
  output logic                            err_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            busy_o,
  output logic                            ctl_rd_i_stb,
  input  logic                            ctl_rd_i_ack,
  input  logic                            ctl_rd_o_stb,
  output logic                            ctl_rd_o_ack,
  output logic [ADR_WIDTH-1:0]            ctl_rd_adr,
  input  logic [DATA_WIDTH-1:0]           ctl_rd_data,
  output logic                            ctl_wt_i_stb,
  input  logic                            ctl_wt_i_ack,
  input  logic                            ctl_wt_o_stb,
  output logic                            ctl_wt_o_ack,
  output logic [ADR_WIDTH-1:0]            ctl_wt_adr,
  output logic [DATA_WIDTH-1:0]           ctl_wt_data
);

  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [7:0] WdLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         rr_q, rr_d, port_q, port_d;
  logic                  we_q, we_d;
  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]            wd_q, wd_d;
  logic [NUM_PORTS-1:0]  ack_q, ack_d, done_q, done_d;
  logic                  err_q, err_d, busy_q, busy_d;
  logic                  rd_stb_q, rd_stb_d, wt_stb_q, wt_stb_d;

  logic                  grant_vld;
  logic [PW-1:0]         grant_idx, cand_idx;

  // Search starts just after the last winner, so the port served last has lowest priority.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand_idx = PW'((32'(rr_q) + i) % NUM_PORTS);
      if (!grant_vld && req_i[cand_idx]) begin
        grant_vld = 1'b1;
        grant_idx = cand_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    port_d   = port_q;
    we_d     = we_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    wd_d     = wd_q;
    rd_stb_d = rd_stb_q;
    wt_stb_d = wt_stb_q;
    ack_d    = '0;
    done_d   = '0;
    case (state_q)
      StIdle: begin
        if (grant_vld) begin
          state_d          = StIssue;
          rr_d             = grant_idx;
          port_d           = grant_idx;
          we_d             = we_i[grant_idx];
          adr_d            = adr_i[grant_idx*ADR_WIDTH +: ADR_WIDTH];
          wdata_d          = wdata_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          ack_d[grant_idx] = 1'b1;
          wt_stb_d         = we_i[grant_idx];
          rd_stb_d         = !we_i[grant_idx];
        end
      end
      StIssue: begin
        // No timeout here: the controller may legitimately stall during init or refresh.
        if (we_q ? ctl_wt_i_ack : ctl_rd_i_ack) begin
          rd_stb_d = 1'b0;
          wt_stb_d = 1'b0;
          wd_d     = '0;
          state_d  = StWait;
        end
      end
      StWait: begin
        if (we_q ? ctl_wt_o_stb : ctl_rd_o_stb) begin
          done_d[port_q] = 1'b1;
          err_d          = 1'b0;
          if (!we_q) rdata_d = ctl_rd_data;
          state_d        = StIdle;
        end else if (wd_q == WdLast) begin
          done_d[port_q] = 1'b1;
          err_d          = 1'b1;
          state_d        = StIdle;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      default: begin
        state_d  = StIdle;
        rd_stb_d = 1'b0;
        wt_stb_d = 1'b0;
      end
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      rr_q     <= PW'(NUM_PORTS - 1);
      port_q   <= '0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
      rd_stb_q <= 1'b0;
      wt_stb_q <= 1'b0;
      ack_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      port_q   <= port_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
      rd_stb_q <= rd_stb_d;
      wt_stb_q <= wt_stb_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign ack_o        = ack_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign busy_o       = busy_q;
  assign ctl_rd_i_stb = rd_stb_q;
  assign ctl_wt_i_stb = wt_stb_q;
  assign ctl_rd_adr   = adr_q;
  assign ctl_wt_adr   = adr_q;
  assign ctl_wt_data  = wdata_q;
  // Completion strobes are acknowledged only while a transaction is waiting for them.
  assign ctl_rd_o_ack = (state_q == StWait) && ctl_rd_o_stb;
  assign ctl_wt_o_ack = (state_q == StWait) && ctl_wt_o_stb;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus randomized traffic against a
// transaction-level reference model checked every cycle.
module tb_sdram_port_arbiter;

  localparam int NP = 4;
  localparam int DW = 16;
  localparam int AW = 24;
  localparam int TO = 64;

  logic             CLK = 1'b0;
  logic             RST;
  logic [NP-1:0]    req_i, we_i;
  logic [NP*AW-1:0] adr_i;
  logic [NP*DW-1:0] wdata_i;
  logic [NP-1:0]    ack_o, done_o;
  logic             err_o, busy_o;
  logic [DW-1:0]    rdata_o;
  logic             ctl_rd_i_stb, ctl_rd_i_ack, ctl_rd_o_stb, ctl_rd_o_ack;
  logic             ctl_wt_i_stb, ctl_wt_i_ack, ctl_wt_o_stb, ctl_wt_o_ack;
  logic [AW-1:0]    ctl_rd_adr, ctl_wt_adr;
  logic [DW-1:0]    ctl_rd_data, ctl_wt_data;

  sdram_port_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK(CLK), .RST(RST), .req_i(req_i), .we_i(we_i), .adr_i(adr_i), .wdata_i(wdata_i),
    .ack_o(ack_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .ctl_rd_i_stb(ctl_rd_i_stb), .ctl_rd_i_ack(ctl_rd_i_ack), .ctl_rd_o_stb(ctl_rd_o_stb),
    .ctl_rd_o_ack(ctl_rd_o_ack), .ctl_rd_adr(ctl_rd_adr), .ctl_rd_data(ctl_rd_data),
    .ctl_wt_i_stb(ctl_wt_i_stb), .ctl_wt_i_ack(ctl_wt_i_ack), .ctl_wt_o_stb(ctl_wt_o_stb),
    .ctl_wt_o_ack(ctl_wt_o_ack), .ctl_wt_adr(ctl_wt_adr), .ctl_wt_data(ctl_wt_data)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int unsigned cycle = 0;
  int grants[$];

  always @(posedge CLK) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int            m_phase, m_last, m_port, m_edges, m_start;  // phase: 0 free, 1 issuing, 2 waiting
  bit            m_we;
  logic [AW-1:0] m_adr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          m_err;
  logic [NP-1:0] m_ack, m_done;

  function automatic int next_port(input logic [NP-1:0] r, input int last);
    for (int i = 1; i <= NP; i++) if (r[(last + i) % NP]) return (last + i) % NP;
    return -1;
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      m_phase = 0; m_last = NP - 1; m_port = 0; m_we = 0; m_adr = '0; m_wdata = '0;
      m_rdata = '0; m_err = 0; m_ack = '0; m_done = '0; m_edges = 0; m_start = 0;
    end else begin
      m_edges++;
      m_ack  = '0;
      m_done = '0;
      case (m_phase)
        0: if (req_i != '0) begin
          m_port = next_port(req_i, m_last);
          m_last = m_port;
          m_we = we_i[m_port];
          m_adr = adr_i[m_port*AW +: AW];
          m_wdata = wdata_i[m_port*DW +: DW];
          m_ack[m_port] = 1'b1;
          m_phase = 1;
        end
        1: if (m_we ? ctl_wt_i_ack : ctl_rd_i_ack) begin
          m_phase = 2;
          m_start = m_edges;
        end
        default: if (m_we ? ctl_wt_o_stb : ctl_rd_o_stb) begin
          m_done[m_port] = 1'b1;
          m_err = 0;
          if (!m_we) m_rdata = ctl_rd_data;
          m_phase = 0;
        end else if (m_edges - m_start == TO) begin
          m_done[m_port] = 1'b1;
          m_err = 1;
          m_phase = 0;
        end
      endcase
    end
  end

  always @(negedge CLK) begin
    check("ack_o", 64'(ack_o), 64'(m_ack));
    check("done_o", 64'(done_o), 64'(m_done));
    check("err_o", 64'(err_o), 64'(m_err));
    check("rdata_o", 64'(rdata_o), 64'(m_rdata));
    check("busy_o", 64'(busy_o), 64'(m_phase != 0));
    check("rd_i_stb", 64'(ctl_rd_i_stb), 64'(m_phase == 1 && !m_we));
    check("wt_i_stb", 64'(ctl_wt_i_stb), 64'(m_phase == 1 && m_we));
    check("rd_o_ack", 64'(ctl_rd_o_ack), 64'(m_phase == 2 && ctl_rd_o_stb));
    check("wt_o_ack", 64'(ctl_wt_o_ack), 64'(m_phase == 2 && ctl_wt_o_stb));
    check("rd_adr", 64'(ctl_rd_adr), 64'(m_adr));
    check("wt_adr", 64'(ctl_wt_adr), 64'(m_adr));
    check("wt_data", 64'(ctl_wt_data), 64'(m_wdata));
    for (int k = 0; k < NP; k++) if (ack_o[k]) grants.push_back(k);
  end

  // ---------------- controller emulation ----------------
  int ctl_ack_dly = 2, ctl_ostb_dly = 6;
  bit ctl_drop = 0, ctl_rand = 0;
  int late_req = 0, late_seen = 0;
  int cphase = 0, ccnt = 0, odly = 1;
  bit cwe = 0, cdrop = 0;

  always @(posedge CLK) begin
    #1;
    ctl_rd_i_ack = 0; ctl_wt_i_ack = 0; ctl_rd_o_stb = 0; ctl_wt_o_stb = 0;
    if (RST) begin
      cphase = 0;
    end else begin
      if (late_req != late_seen) begin
        late_seen = late_req;
        ctl_rd_o_stb = 1; ctl_wt_o_stb = 1;
      end
      if (cphase == 0 && (ctl_rd_i_stb || ctl_wt_i_stb)) begin
        cwe = ctl_wt_i_stb;
        cphase = 1;
        if (ctl_rand) begin
          ccnt = $urandom_range(0, 3); odly = $urandom_range(1, 8);
          cdrop = ($urandom_range(0, 15) == 0);
        end else begin
          ccnt = ctl_ack_dly; odly = ctl_ostb_dly; cdrop = ctl_drop;
        end
      end else if (cphase == 0 && ctl_rand && $urandom_range(0, 31) == 0) begin
        ctl_rd_o_stb = 1; ctl_wt_o_stb = 1;  // stray strobe
      end
      if (cphase == 1) begin
        if (ccnt == 0) begin
          if (cwe) ctl_wt_i_ack = 1; else ctl_rd_i_ack = 1;
          ccnt = odly;
          cphase = 2;
        end else ccnt--;
      end else if (cphase == 2) begin
        ccnt--;
        if (ccnt == 0) begin
          if (!cdrop) begin
            if (cwe) ctl_wt_o_stb = 1; else ctl_rd_o_stb = 1;
          end
          cphase = 0;
        end
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  int t0, n, dcnt;
  int exp_rr_a[6] = '{0, 1, 2, 3, 0, 1};
  int exp_rr_b[7] = '{0, 1, 2, 3, 0, 2, 3};

  task automatic wait_done(input int port, input int max_cyc);
    int k = 0;
    @(negedge CLK);
    while (!done_o[port] && k < max_cyc) begin
      @(negedge CLK);
      k++;
    end
    check("done_seen", 64'(done_o[port]), 64'd1);
  endtask

  task automatic wait_grants(input int cnt);
    int k = 0;
    while (grants.size() < cnt && k < 300) begin
      @(negedge CLK);
      if (ack_o[1] && cnt == 7) req_i[1] = 1'b0;
      k++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench time limit");
  end

  initial begin
    RST = 1; req_i = '0; we_i = '0; adr_i = '0; wdata_i = '0; ctl_rd_data = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_ack", 64'(ack_o), 64'd0);
    check("rst_wt_adr", 64'(ctl_wt_adr), 64'd0);
    RST = 0;

    // single write, port 2
    @(posedge CLK); #1; t0 = cycle;
    req_i[2] = 1; we_i[2] = 1; adr_i[2*AW +: AW] = 24'h40_0010; wdata_i[2*DW +: DW] = 16'hBEEF;
    @(posedge CLK); @(negedge CLK);
    check("wr_ack", 64'(ack_o), 64'h4);
    check("wr_stb", 64'(ctl_wt_i_stb), 64'd1);
    check("wr_adr", 64'(ctl_wt_adr), 64'h40_0010);
    check("wr_data", 64'(ctl_wt_data), 64'hBEEF);
    req_i = '0; adr_i = '0; wdata_i = '0;
    wait_done(2, 50);
    check("wr_latency", 64'(cycle - t0), 64'd10);
    check("wr_err", 64'(err_o), 64'd0);

    // single read, port 0
    ctl_rd_data = 16'h1234;
    @(posedge CLK); #1;
    req_i[0] = 1; we_i[0] = 0; adr_i[0 +: AW] = 24'h01_0203;
    @(posedge CLK); @(negedge CLK);
    check("rd_ack", 64'(ack_o), 64'h1);
    check("rd_adr_lit", 64'(ctl_rd_adr), 64'h01_0203);
    req_i = '0;
    n = 0;
    while (!ctl_rd_o_stb && n < 50) begin @(negedge CLK); n++; end
    check("rd_oack_hi", 64'(ctl_rd_o_ack), 64'd1);
    @(negedge CLK);
    check("rd_done", 64'(done_o), 64'h1);
    check("rd_data", 64'(rdata_o), 64'h1234);
    check("rd_oack_lo", 64'(ctl_rd_o_ack), 64'd0);

    // stalled issue ack for 500 cycles, port 3 write
    ctl_ack_dly = 500;
    @(posedge CLK); #1; t0 = cycle;
    req_i[3] = 1; we_i[3] = 1; adr_i[3*AW +: AW] = 24'h00_0123; wdata_i[3*DW +: DW] = 16'h5A5A;
    @(posedge CLK); @(negedge CLK);
    check("st_ack", 64'(ack_o), 64'h8);
    req_i = '0;
    repeat (500) @(negedge CLK);
    check("st_stb_held", 64'(ctl_wt_i_stb), 64'd1);
    check("st_no_err", 64'(err_o), 64'd0);
    wait_done(3, 50);
    check("st_latency", 64'(cycle - t0), 64'd508);
    check("st_err", 64'(err_o), 64'd0);

    // watchdog timeout, port 1 write, completion strobe never comes
    ctl_ack_dly = 2; ctl_drop = 1;
    @(posedge CLK); #1; t0 = cycle;
    req_i[1] = 1; we_i[1] = 1;
    @(posedge CLK); @(negedge CLK);
    req_i = '0;
    wait_done(1, 100);
    check("to_latency", 64'(cycle - t0), 64'(4 + TO));
    check("to_err", 64'(err_o), 64'd1);
    repeat (10) @(negedge CLK);
    late_req++;
    dcnt = 0;
    repeat (6) begin @(negedge CLK); if (done_o != '0) dcnt++; end
    check("late_ostb_ignored", 64'(dcnt), 64'd0);

    // reset while waiting
    ctl_ack_dly = 0;
    @(posedge CLK); #1;
    req_i[3] = 1; we_i[3] = 1;
    @(posedge CLK); @(negedge CLK);
    req_i = '0;
    repeat (2) @(negedge CLK);
    check("mid_busy", 64'(busy_o), 64'd1);
    #1 RST = 1;
    #1;
    check("mid_rst_busy", 64'(busy_o), 64'd0);
    check("mid_rst_stb", 64'({ctl_wt_i_stb, ctl_rd_i_stb}), 64'd0);
    check("mid_rst_done", 64'(done_o), 64'd0);
    ctl_drop = 0; ctl_ostb_dly = 1;
    req_i = '1; we_i = 4'b0101;
    @(negedge CLK); grants.delete();
    @(negedge CLK); RST = 0;

    // round robin with all ports requesting
    wait_grants(6);
    for (int i = 0; i < 6; i++)
      check($sformatf("rr_a%0d", i), 64'((grants.size() > i) ? grants[i] : -1), 64'(exp_rr_a[i]));

    @(negedge CLK); RST = 1; req_i = '1;
    @(negedge CLK); grants.delete();
    @(negedge CLK); RST = 0;
    wait_grants(7);
    for (int i = 0; i < 7; i++)
      check($sformatf("rr_b%0d", i), 64'((grants.size() > i) ? grants[i] : -1), 64'(exp_rr_b[i]));

    // randomized traffic
    req_i = '0;
    @(negedge CLK); RST = 1;
    @(negedge CLK); RST = 0;
    ctl_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge CLK); #1;
      for (int k = 0; k < NP; k++) begin
        if (ack_o[k] || !req_i[k]) begin
          we_i[k] = 1'($urandom_range(0, 1));
          adr_i[k*AW +: AW] = AW'($urandom);
          wdata_i[k*DW +: DW] = DW'($urandom);
        end
        if (ack_o[k]) req_i[k] = 1'($urandom_range(0, 1));
        else if (!req_i[k]) req_i[k] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 39) == 0) req_i[k] = 1'b0;
      end
      ctl_rd_data = DW'($urandom);
    end
    req_i = '0;
    n = 0;
    while (busy_o && n < 300) begin @(negedge CLK); n++; end
    check("drain_idle", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
